banked_mem_responder: RTL and testbench

//   Memory-side responder for the cache controller's memory port (addr/data_in/wr/rd out,

---
 rtl/banked_mem_responder.sv | 112 +++++++++++
 tb/tb_banked_mem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/banked_mem_responder.sv
// Four interleaved single-ported banks behind a one-request-per-cycle memory port.
// Busy banks stall new requests; reads return in issue order after a fixed latency.

module banked_mem_bank #(
    parameter int BUSY_CYCLES = 4,
    parameter int ROW_BITS    = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel,
    input  logic                we,
    input  logic [ROW_BITS-1:0] row,
    input  logic [15:0]         wdata,
    output logic [15:0]         rdata,
    output logic                busy
);
    localparam int ROWS = 2 ** ROW_BITS;
    localparam int CW   = $clog2(BUSY_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic [15:0]   mem [ROWS];

    // Occupancy counter saturates at zero; busy is a pure function of state.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (sel)
            cnt <= CW'(BUSY_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (sel && we)
            mem[row] <= wdata;
    end

    assign rdata = mem[row];
    assign busy  = (cnt != '0);
endmodule

module banked_mem_responder #(
    parameter int BUSY_CYCLES  = 4,
    parameter int READ_LATENCY = 2,
    parameter int ROW_BITS     = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        done,
    output logic [3:0]  busy,
    output logic        stall,
    output logic        err
);
    localparam int NUM_BANKS = 4;

    logic                            req, accept, rd_acc;
    logic [1:0]                      bank;
    logic [ROW_BITS-1:0]             row;
    logic [NUM_BANKS-1:0][15:0]      bank_word;
    logic [READ_LATENCY:1]           vld_pipe;
    logic [READ_LATENCY:1][15:0]     dat_pipe;

    assign bank   = addr[2:1];
    assign row    = addr[ROW_BITS+2:3];
    assign req    = rd | wr;
    assign err    = ~rst & req & (addr[0] | (rd & wr));
    assign stall  = ~rst & req & ~err & busy[bank];
    assign accept = ~rst & req & ~err & ~stall;
    assign rd_acc = accept & rd;

    genvar g;
    generate
        for (g = 0; g < NUM_BANKS; g++) begin : g_bank
            banked_mem_bank #(
                .BUSY_CYCLES (BUSY_CYCLES),
                .ROW_BITS    (ROW_BITS)
            ) u_bank (
                .clk   (clk),
                .rst   (rst),
                .sel   (accept && (bank == 2'(g))),
                .we    (wr),
                .row   (row),
                .wdata (data_in),
                .rdata (bank_word[g]),
                .busy  (busy[g])
            );
        end
    endgenerate

    // Read word is captured in the accept cycle, so a later write cannot alter it.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            dat_pipe[1] <= bank_word[bank];
            for (int i = 2; i <= READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign done     = vld_pipe[READ_LATENCY];
    assign data_out = done ? dat_pipe[READ_LATENCY] : 16'h0000;
endmodule

// File: tb/tb_banked_mem_responder.sv
// Randomized + directed bench: cycle-level model of bank occupancy and read returns,
// with a monitor that pops expected read data whenever the DUT signals done.

module tb_banked_mem_responder;
    localparam int BUSY = 4;
    localparam int RL   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr, data_in, data_out;
    logic        wr, rd, done, stall, err;
    logic [3:0]  busy;

    banked_mem_responder #(
        .BUSY_CYCLES  (BUSY),
        .READ_LATENCY (RL),
        .ROW_BITS     (13)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .done     (done),
        .busy     (busy),
        .stall    (stall),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mdl [int];
    int          acc_cyc [4];
    int          cyc = 0;
    int          nchk = 0;
    int          nerr = 0;
    bit          started = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, expv);
        end
    endtask

    // One cycle of stimulus: model predicts err/stall/busy, then commits at the edge.
    task automatic step(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d,
                        input bit rs, output bit acc);
        int         b;
        bit         e_err, e_stall;
        logic [3:0] e_busy;
        rd = r; wr = w; addr = a; data_in = d; rst = rs;
        b = int'(a[2:1]);
        for (int k = 0; k < 4; k++)
            e_busy[k] = (cyc >= acc_cyc[k] + 1) && (cyc <= acc_cyc[k] + BUSY);
        e_err   = !rs && (r || w) && (a[0] || (r && w));
        e_stall = !rs && (r || w) && !e_err && e_busy[b];
        acc     = !rs && (r || w) && !e_err && !e_stall;
        @(negedge clk);
        check("busy", busy, e_busy);
        check("err", err, e_err);
        check("stall", stall, e_stall);
        @(posedge clk);
        if (rs) begin
            for (int k = 0; k < 4; k++) acc_cyc[k] = -100;
            exp_q.delete();
        end else if (acc) begin
            acc_cyc[b] = cyc;
            if (w)
                mdl[int'(a[15:1])] = d;
            else
                exp_q.push_back('{data: mdl[int'(a[15:1])], due: cyc + RL});
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 0, 16'h0000, 16'h0000, 0, acc);
    endtask

    task automatic must_write(input logic [15:0] a, input logic [15:0] d);
        bit acc;
        acc = 0;
        while (!acc) step(0, 1, a, d, 0, acc);
    endtask

    // Monitor: every done pops one expected read; otherwise data_out must be zero.
    always @(negedge clk) begin
        if (started) begin
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.due);
                    check("data_out", data_out, e.data);
                end
            end else begin
                check("idle_data_out", data_out, 16'h0000);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc)
                    check("missing_done", done, 1);
            end
        end
    end

    initial begin
        bit acc;
        for (int k = 0; k < 4; k++) acc_cyc[k] = -100;
        rst = 1; rd = 0; wr = 0; addr = '0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        started = 1;

        // write then read back with busy window and exact-latency return
        step(0, 1, 16'h0010, 16'hBEEF, 0, acc);
        idle(4);
        step(1, 0, 16'h0010, 16'h0000, 0, acc);
        idle(5);
        must_write(16'h0012, 16'h1234);
        must_write(16'h0018, 16'h5678);
        must_write(16'h0020, 16'h9ABC);
        idle(5);

        // overlapping reads to different banks
        step(1, 0, 16'h0010, 16'h0000, 0, acc);
        step(1, 0, 16'h0012, 16'h0000, 0, acc);
        idle(5);

        // same-bank conflict, stall then reissue
        step(1, 0, 16'h0010, 16'h0000, 0, acc);
        idle(1);
        step(1, 0, 16'h0018, 16'h0000, 0, acc);
        idle(2);
        step(1, 0, 16'h0018, 16'h0000, 0, acc);
        idle(5);

        // illegal requests are dropped and leave the array untouched
        step(1, 0, 16'h0011, 16'h0000, 0, acc);
        step(1, 1, 16'h0020, 16'hFFFF, 0, acc);
        idle(2);
        step(1, 0, 16'h0020, 16'h0000, 0, acc);
        idle(5);

        // reset discards in-flight read, contents survive
        step(1, 0, 16'h0010, 16'h0000, 0, acc);
        step(0, 0, 16'h0000, 16'h0000, 1, acc);
        idle(5);
        step(1, 0, 16'h0010, 16'h0000, 0, acc);
        idle(5);

        // initialise a small random working set, then random traffic
        for (int row = 0; row < 8; row++)
            for (int b = 0; b < 4; b++)
                must_write(16'((row << 3) | (b << 1)), 16'($urandom));
        for (int i = 0; i < 400; i++) begin
            int          x;
            bit          r, w, rs;
            logic [15:0] a;
            x  = $urandom_range(0, 99);
            r  = (x < 35) || (x >= 70 && x < 74);
            w  = (x >= 35 && x < 74);
            rs = ($urandom_range(0, 59) == 0);
            a  = 16'(($urandom_range(0, 7) << 3) | ($urandom_range(0, 3) << 1)
                     | ($urandom_range(0, 19) == 0 ? 1 : 0));
            step(r, w, a, 16'($urandom), rs, acc);
        end
        idle(6);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
